// File: rtl/ptw_axi_arbiter_if.sv
// ptw_axi_arbiter_if: ITLB/DTLB walk ports plus the shared AXI master read port
interface ptw_axi_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  ITLB_ADDR_VALID;
    logic [ADDR_WIDTH-1:0] ITLB_ADDR;
    logic                  ITLB_KILL;
    logic                  ITLB_DATA_VALID;
    logic [DATA_WIDTH-1:0] ITLB_DATA;
    logic                  DTLB_ADDR_VALID;
    logic [ADDR_WIDTH-1:0] DTLB_ADDR;
    logic                  DTLB_KILL;
    logic                  DTLB_DATA_VALID;
    logic [DATA_WIDTH-1:0] DTLB_DATA;
    logic                  ADDR_TO_AXIM_VALID;
    logic [ADDR_WIDTH-1:0] ADDR_TO_AXIM;
    logic                  AXIM_READY;
    logic                  DATA_FROM_AXIM_VALID;
    logic [DATA_WIDTH-1:0] DATA_FROM_AXIM;
    logic                  OVERRUN;
    modport slave (
        input  ITLB_ADDR_VALID, ITLB_ADDR, ITLB_KILL, DTLB_ADDR_VALID, DTLB_ADDR, DTLB_KILL,
        input  AXIM_READY, DATA_FROM_AXIM_VALID, DATA_FROM_AXIM,
        output ITLB_DATA_VALID, ITLB_DATA, DTLB_DATA_VALID, DTLB_DATA,
        output ADDR_TO_AXIM_VALID, ADDR_TO_AXIM, OVERRUN
    );
    modport master (
        output ITLB_ADDR_VALID, ITLB_ADDR, ITLB_KILL, DTLB_ADDR_VALID, DTLB_ADDR, DTLB_KILL,
        output AXIM_READY, DATA_FROM_AXIM_VALID, DATA_FROM_AXIM,
        input  ITLB_DATA_VALID, ITLB_DATA, DTLB_DATA_VALID, DTLB_DATA,
        input  ADDR_TO_AXIM_VALID, ADDR_TO_AXIM, OVERRUN
    );
endinterface

// File: rtl/ptw_axi_arbiter.sv
// ptw_axi_arbiter: round-robin sharing of one PTW AXI read port between ITLB (index 0) and DTLB (index 1)
module ptw_axi_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic              CLK,
    input logic              RST,
    ptw_axi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                state_q, state_d;
    logic                  owner_q, owner_d, last_q, last_d, overrun_q, overrun_d, win;
    logic [1:0]            pend_q, pend_d, kill_q, kill_d, dv_q, dv_d;
    logic [1:0]            req_v, kill_in, elig, owns, done, grant;
    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [ADDR_WIDTH-1:0] addr_d [2];
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [ADDR_WIDTH-1:0] axi_addr_q, axi_addr_d;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];

    assign req_v       = {bus.DTLB_ADDR_VALID, bus.ITLB_ADDR_VALID};
    assign kill_in     = {bus.DTLB_KILL, bus.ITLB_KILL};
    assign req_addr[0] = bus.ITLB_ADDR;
    assign req_addr[1] = bus.DTLB_ADDR;
    // A slot being killed or overwritten this cycle sits out arbitration so its stale address never issues
    assign elig  = pend_q & ~kill_in & ~req_v;
    assign win   = &elig ? ~last_q : elig[1];
    assign owns  = state_q == IDLE ? 2'b00 : owner_q ? 2'b10 : 2'b01;
    assign done  = state_q == WAIT && bus.DATA_FROM_AXIM_VALID ? owns : 2'b00;
    assign grant = state_q == IDLE && |elig ? (win ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d    = state_q == IDLE  ? (|elig ? ISSUE : IDLE) :
                     state_q == ISSUE ? (bus.AXIM_READY ? WAIT : ISSUE) :
                     state_q == WAIT  ? (bus.DATA_FROM_AXIM_VALID ? IDLE : WAIT) : IDLE;
        owner_d    = |grant ? win : owner_q;
        last_d     = |grant ? win : last_q;
        axi_addr_d = |grant ? addr_q[win] : axi_addr_q;
        // pend holds only ungranted requests; the owned request is tracked by owner/state
        pend_d     = req_v | (pend_q & ~kill_in & ~grant);
        kill_d     = ~done & (kill_q | (owns & kill_in));
        dv_d       = done & ~kill_q & ~kill_in;
        overrun_d  = overrun_q | (|(req_v & (pend_q | owns) & ~done));
        for (int x = 0; x < 2; x++) begin
            addr_d[x] = req_v[x] ? req_addr[x] : addr_q[x];
            data_d[x] = dv_d[x] ? bus.DATA_FROM_AXIM : data_q[x];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            overrun_q  <= 1'b0;
            pend_q     <= '0;
            kill_q     <= '0;
            dv_q       <= '0;
            axi_addr_q <= '0;
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            overrun_q  <= overrun_d;
            pend_q     <= pend_d;
            kill_q     <= kill_d;
            dv_q       <= dv_d;
            axi_addr_q <= axi_addr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.ADDR_TO_AXIM_VALID = state_q == ISSUE;
    assign bus.ADDR_TO_AXIM       = axi_addr_q;
    assign bus.ITLB_DATA_VALID    = dv_q[0];
    assign bus.ITLB_DATA          = data_q[0];
    assign bus.DTLB_DATA_VALID    = dv_q[1];
    assign bus.DTLB_DATA          = data_q[1];
    assign bus.OVERRUN            = overrun_q;
endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// tb_ptw_axi_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_ptw_axi_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ptw_axi_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();
    ptw_axi_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    // model: waiting request per TLB, one walk on the port, round-robin memory
    bit          m_wv [2];
    logic [63:0] m_wa [2];
    bit          m_busy, m_acc, m_kill, m_who, m_last;
    logic [63:0] m_paddr;
    bit          e_av, e_ovr;
    bit          e_dv [2];
    logic [63:0] e_addr;
    logic [63:0] e_data [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit req [2];
        bit kil [2];
        logic [63:0] ra [2];
        bit elig [2];
        bit completing, was_busy, old_who;
        int pick;
        req = '{bus.ITLB_ADDR_VALID, bus.DTLB_ADDR_VALID};
        kil = '{bus.ITLB_KILL, bus.DTLB_KILL};
        ra  = '{bus.ITLB_ADDR, bus.DTLB_ADDR};
        if (rst) begin
            m_wv = '{0, 0}; m_busy = 0; m_acc = 0; m_kill = 0; m_who = 0; m_last = 1;
            e_av = 0; e_addr = 0; e_dv = '{0, 0}; e_data = '{64'h0, 64'h0}; e_ovr = 0;
            return;
        end
        was_busy = m_busy;
        old_who = m_who;
        completing = m_busy && m_acc && bus.DATA_FROM_AXIM_VALID;
        e_dv = '{0, 0};
        if (completing && !m_kill && !kil[m_who]) begin
            e_dv[m_who] = 1;
            e_data[m_who] = bus.DATA_FROM_AXIM;
        end
        for (int x = 0; x < 2; x++)
            if (req[x] && (m_wv[x] || (m_busy && m_who == x[0])) && !(completing && m_who == x[0])) e_ovr = 1;
        if (!was_busy) begin
            for (int x = 0; x < 2; x++) elig[x] = m_wv[x] && !kil[x] && !req[x];
            pick = (elig[0] && elig[1]) ? (m_last ? 0 : 1) : elig[0] ? 0 : elig[1] ? 1 : -1;
            if (pick >= 0) begin
                m_busy = 1; m_acc = 0; m_kill = 0;
                m_who = pick[0]; m_last = pick[0];
                m_paddr = m_wa[pick]; m_wv[pick] = 0;
            end
        end
        for (int x = 0; x < 2; x++)
            if (kil[x]) begin
                m_wv[x] = 0;
                if (was_busy && old_who == x[0]) m_kill = 1;
            end
        if (was_busy && !m_acc && bus.AXIM_READY) m_acc = 1;
        if (completing) begin m_busy = 0; m_acc = 0; m_kill = 0; end
        for (int x = 0; x < 2; x++)
            if (req[x]) begin m_wv[x] = 1; m_wa[x] = ra[x]; end
        e_av = m_busy && !m_acc;
        if (e_av) e_addr = m_paddr;
    endtask

    task automatic compare();
        chk("axi_valid", bus.ADDR_TO_AXIM_VALID, e_av);
        if (e_av) chk("axi_addr", bus.ADDR_TO_AXIM, e_addr);
        chk("itlb_dv", bus.ITLB_DATA_VALID, e_dv[0]);
        chk("dtlb_dv", bus.DTLB_DATA_VALID, e_dv[1]);
        chk("itlb_data", bus.ITLB_DATA, e_data[0]);
        chk("dtlb_data", bus.DTLB_DATA, e_data[1]);
        chk("overrun", bus.OVERRUN, e_ovr);
    endtask

    task automatic clear_pulses();
        bus.ITLB_ADDR_VALID = 0; bus.DTLB_ADDR_VALID = 0;
        bus.ITLB_KILL = 0; bus.DTLB_KILL = 0;
        bus.DATA_FROM_AXIM_VALID = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
        clear_pulses();
    endtask

    task automatic req(input bit d, input logic [63:0] a);
        if (d) begin bus.DTLB_ADDR_VALID = 1; bus.DTLB_ADDR = a; end
        else begin bus.ITLB_ADDR_VALID = 1; bus.ITLB_ADDR = a; end
    endtask

    task automatic ret(input logic [63:0] v);
        bus.DATA_FROM_AXIM_VALID = 1;
        bus.DATA_FROM_AXIM = v;
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        int vcnt;
        clear_pulses();
        bus.ITLB_ADDR = 0; bus.DTLB_ADDR = 0; bus.AXIM_READY = 0; bus.DATA_FROM_AXIM = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_axi_valid", bus.ADDR_TO_AXIM_VALID, 0);
        chk("rst_axi_addr", bus.ADDR_TO_AXIM, 0);
        chk("rst_itlb_dv", bus.ITLB_DATA_VALID, 0);
        chk("rst_dtlb_dv", bus.DTLB_DATA_VALID, 0);
        chk("rst_itlb_data", bus.ITLB_DATA, 0);
        chk("rst_dtlb_data", bus.DTLB_DATA, 0);
        chk("rst_overrun", bus.OVERRUN, 0);

        // single ITLB walk
        bus.AXIM_READY = 1;
        req(0, 64'h8000_1000);
        tick();
        chk("single_not_yet", bus.ADDR_TO_AXIM_VALID, 0);
        tick();
        chk("single_issue_valid", bus.ADDR_TO_AXIM_VALID, 1);
        chk("single_issue_addr", bus.ADDR_TO_AXIM, 64'h8000_1000);
        tick();
        chk("single_valid_drop", bus.ADDR_TO_AXIM_VALID, 0);
        ret(64'h0000_0000_2000_00CF);
        chk("single_itlb_dv", bus.ITLB_DATA_VALID, 1);
        chk("single_itlb_data", bus.ITLB_DATA, 64'h0000_0000_2000_00CF);
        chk("single_dtlb_dv", bus.DTLB_DATA_VALID, 0);
        tick();
        chk("single_dv_one_cycle", bus.ITLB_DATA_VALID, 0);
        chk("single_data_hold", bus.ITLB_DATA, 64'h0000_0000_2000_00CF);

        // simultaneous pair after reset, then round-robin
        do_reset();
        req(0, 64'h1111_0000); req(1, 64'h2222_0000);
        tick(); tick();
        chk("pair1_first_addr", bus.ADDR_TO_AXIM, 64'h1111_0000);
        tick();
        ret(64'hA1);
        chk("pair1_itlb_dv", bus.ITLB_DATA_VALID, 1);
        tick();
        chk("pair1_second_valid", bus.ADDR_TO_AXIM_VALID, 1);
        chk("pair1_second_addr", bus.ADDR_TO_AXIM, 64'h2222_0000);
        tick();
        ret(64'hD1);
        chk("pair1_dtlb_data", bus.DTLB_DATA, 64'hD1);
        req(0, 64'h3333_0000);
        tick(); tick();
        chk("solo_i_addr", bus.ADDR_TO_AXIM, 64'h3333_0000);
        tick();
        ret(64'hA2);
        req(0, 64'h4444_0000); req(1, 64'h5555_0000);
        tick(); tick();
        chk("pair2_d_first", bus.ADDR_TO_AXIM, 64'h5555_0000);
        tick();
        ret(64'hD2);
        tick();
        chk("pair2_i_second", bus.ADDR_TO_AXIM, 64'h4444_0000);
        tick();
        ret(64'hA3);

        // backpressure: READY low 5 cycles
        bus.AXIM_READY = 0;
        req(0, 64'h6666_0000);
        tick();
        vcnt = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) bus.AXIM_READY = 1;
            tick();
            if (bus.ADDR_TO_AXIM_VALID && bus.ADDR_TO_AXIM == 64'h6666_0000) vcnt++;
        end
        chk("bp_valid_cycles", vcnt, 6);
        chk("bp_valid_drop", bus.ADDR_TO_AXIM_VALID, 0);
        ret(64'hA4);

        // kill in flight
        req(1, 64'h7777_0000);
        tick(); tick();
        req(0, 64'h8888_0000);
        tick();
        bus.DTLB_KILL = 1;
        tick();
        ret(64'hDEAD);
        chk("kill_flight_no_dv", bus.DTLB_DATA_VALID, 0);
        chk("kill_flight_data_hold", bus.DTLB_DATA, 64'hD2);
        tick();
        chk("kill_flight_i_issues", bus.ADDR_TO_AXIM, 64'h8888_0000);
        tick();
        ret(64'hA5);
        chk("kill_flight_i_dv", bus.ITLB_DATA_VALID, 1);

        // kill before grant
        bus.AXIM_READY = 0;
        req(1, 64'h9999_0000);
        tick(); tick();
        req(0, 64'hAAAA_0000);
        tick();
        bus.ITLB_KILL = 1;
        tick();
        bus.AXIM_READY = 1;
        tick();
        ret(64'hD3);
        tick();
        chk("kill_pend_no_issue", bus.ADDR_TO_AXIM_VALID, 0);
        tick();
        chk("kill_pend_no_issue2", bus.ADDR_TO_AXIM_VALID, 0);

        // kill and new request in the same cycle
        bus.AXIM_READY = 0;
        req(1, 64'hBBBB_0000);
        tick(); tick();
        req(0, 64'hCCCC_0000);
        tick();
        bus.ITLB_KILL = 1;
        req(0, 64'hCCCC_1000);
        tick();
        bus.AXIM_READY = 1;
        tick();
        ret(64'hD4);
        tick();
        chk("killreq_new_addr", bus.ADDR_TO_AXIM, 64'hCCCC_1000);
        tick();
        ret(64'hA6);

        // overrun, then reset mid-walk
        do_reset();
        bus.AXIM_READY = 0;
        req(1, 64'hDDDD_0000);
        tick(); tick();
        req(0, 64'hEEEE_0000);
        tick();
        chk("ovr_not_yet", bus.OVERRUN, 0);
        req(0, 64'hEEEE_1000);
        tick();
        chk("ovr_set", bus.OVERRUN, 1);
        bus.AXIM_READY = 1;
        tick();
        ret(64'hD5);
        tick();
        chk("ovr_latest_addr", bus.ADDR_TO_AXIM, 64'hEEEE_1000);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rstwalk_axi_valid", bus.ADDR_TO_AXIM_VALID, 0);
        chk("rstwalk_overrun", bus.OVERRUN, 0);
        chk("rstwalk_itlb_data", bus.ITLB_DATA, 0);
        ret(64'hBAD);
        chk("stray_itlb_dv", bus.ITLB_DATA_VALID, 0);
        chk("stray_dtlb_dv", bus.DTLB_DATA_VALID, 0);
        chk("stray_axi_valid", bus.ADDR_TO_AXIM_VALID, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.ITLB_ADDR_VALID = ($urandom_range(0, 5) == 0);
            bus.ITLB_ADDR = {$urandom(), $urandom()};
            bus.DTLB_ADDR_VALID = ($urandom_range(0, 5) == 0);
            bus.DTLB_ADDR = {$urandom(), $urandom()};
            bus.ITLB_KILL = ($urandom_range(0, 11) == 0);
            bus.DTLB_KILL = ($urandom_range(0, 11) == 0);
            bus.AXIM_READY = $urandom_range(0, 1) == 1;
            bus.DATA_FROM_AXIM_VALID = ($urandom_range(0, 2) == 0);
            bus.DATA_FROM_AXIM = {$urandom(), $urandom()};
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ptw_axi_arbiter.md
# ptw_axi_arbiter

Shares the single page-table-walk AXI master read port between the ITLB and the DTLB walkers. Each TLB's one-cycle walk-address pulse is captured into a per-requester pending slot. The block arbitrates round-robin, keeps exactly one walk read outstanding on the AXI master, and routes the returned PTE back to the requester that issued it. It sits between the two TLBs' `ADDR_TO_AXIM*`/`DATA_FROM_AXIM*` pins and the AXI master.

## Interface
Parameters:
- ADDR_WIDTH, 64, walk address width
- DATA_WIDTH, 64, PTE width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ITLB_ADDR_VALID  in  1  one-cycle walk-read request pulse from ITLB
- ITLB_ADDR  in  ADDR_WIDTH  walk address, sampled with ITLB_ADDR_VALID
- ITLB_KILL  in  1  abandon ITLB's current walk read (pending or in flight)
- ITLB_DATA_VALID  out  1  one-cycle PTE return pulse to ITLB
- ITLB_DATA  out  DATA_WIDTH  returned PTE
- DTLB_ADDR_VALID, DTLB_ADDR, DTLB_KILL, DTLB_DATA_VALID, DTLB_DATA: same as the ITLB ports, for the DTLB
- ADDR_TO_AXIM_VALID  out  1  read request to AXI master
- ADDR_TO_AXIM  out  ADDR_WIDTH  read address
- AXIM_READY  in  1  AXI master accepts the request this cycle
- DATA_FROM_AXIM_VALID  in  1  read data valid
- DATA_FROM_AXIM  in  DATA_WIDTH  read data
- OVERRUN  out  1  sticky: a request arrived while that requester's slot was occupied

## Operation
- Per requester X (I or D), the block keeps `pend_X`, `addr_X` and `kill_X`.
  - `X_ADDR_VALID` sets `pend_X`, loads `addr_X` and clears `kill_X`.
- If `X_ADDR_VALID` arrives while `pend_X` is already 1, the new request replaces the stored address and OVERRUN sets (sticky until RST).
  - Exception: the same cycle the slot completes is not an overrun. The set wins and the new request stays pending.
- `X_KILL` has two effects:
  - With `pend_X` set and not yet granted: clears `pend_X`.
  - When X owns the port (ISSUE/WAIT): sets `kill_X`, so the response is consumed and not forwarded.
  - `X_KILL` together with `X_ADDR_VALID` in the same cycle: the new request wins, and the kill applies only to the prior request.
- Round-robin uses the `last` register, reset to D so that I wins the first tie. A grant updates `last` to the granted side.
- FSM states:
  - IDLE: if any `pend_X` is set, pick the winner, latch `owner` and the address into the output register, and go to ISSUE.
  - ISSUE: ADDR_TO_AXIM_VALID=1 and the address is held stable. When AXIM_READY=1, go to WAIT and drop the valid the next cycle.
  - WAIT: on DATA_FROM_AXIM_VALID, capture the data and clear `pend_owner`. If `kill_owner`=0, pulse `owner_DATA_VALID`. Clear `kill_owner` and go to IDLE.
- DATA_FROM_AXIM_VALID in IDLE or ISSUE is ignored.
- Requests are never issued to the AXI master from pending slots cleared by a kill.

## Timing
- Reset values: all outputs are 0, FSM=IDLE, `pend`/`kill`=0, `last`=D. RST mid-walk abandons everything; a late DATA_FROM_AXIM_VALID is ignored.
- Request pulse at cycle t: the slot is set at t+1.
  - The earliest ADDR_TO_AXIM_VALID is at t+2 (IDLE at t+1, then ISSUE).
- ADDR_TO_AXIM_VALID stays high from ISSUE entry through the cycle AXIM_READY is sampled 1, inclusive.
- DATA_FROM_AXIM_VALID at cycle r: `X_DATA_VALID`/`X_DATA` are registered at r+1 and high for exactly 1 cycle. The FSM is in IDLE at r+1, and the next ISSUE is at r+2.
- Both requesters pulse in the same cycle: the winner issues at t+2. The loser issues 2 cycles after the winner's data return.
- X_DATA holds its last value when X_DATA_VALID is low.

## Test plan
- Single ITLB request: ITLB_ADDR=0x8000_1000 at t, AXIM_READY=1 -> ADDR_TO_AXIM_VALID at t+2 with 0x8000_1000. Data 0x0000_0000_2000_00CF returned at r -> ITLB_DATA_VALID with that value at r+1; DTLB_DATA_VALID stays 0.
- Simultaneous I/D requests after reset: I issues first, D issues at r+2. A second simultaneous pair then grants D first (round-robin).
- Backpressure: AXIM_READY low for 5 cycles -> ADDR_TO_AXIM_VALID and the address are held constant for 6 cycles, then deassert.
- Kill in flight: DTLB_KILL during WAIT -> the response is consumed, DTLB_DATA_VALID stays 0, and a pending ITLB request then issues normally.
- Kill before grant, and kill+request in the same cycle: the first drops the request with no AXI issue; the second issues only the new address.
- Overrun plus reset: a second ITLB pulse while pending -> OVERRUN=1 and the latest address is issued. RST during WAIT, followed by a stray DATA_FROM_AXIM_VALID -> all outputs 0 and no DATA_VALID pulse.
